// File: rtl/writeback_unit.sv
// writeback_unit
//   Queues writeback requests from the execute side and retires them in
//   strict FIFO order to either the register file or the PC redirect port.
//   Each queue entry holds the destination select, the resolved register
//   number and the result data. A register-file entry waits at the head
//   until rf_ready is high. PC entries and "none" entries retire without
//   waiting. Writes to register 0 are dropped.
//
//   Optional feature (macro WB_BYPASS_EN): a request that arrives while the
//   queue is empty, and that could retire immediately, is issued straight
//   to the output registers on its accept edge and is never enqueued.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready = count < DEPTH)
//   in_sel                destination: 00 none, 01 rt, 10 rd, 11 pc
//   in_rt, in_rd          candidate register numbers
//   in_data               result value
//   rf_ready              register file accepts a write this cycle
//   rf_we/rf_waddr/rf_wdata   registered register-file write
//   pc_we/pc_value            registered PC redirect
//   count                 current queue occupancy
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_sel,
  input  logic [REG_AW-1:0]      in_rt,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   rf_ready,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   pc_we,
  output logic [DATA_W-1:0]      pc_value,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_RT   = 2'b01;
  localparam logic [1:0] SEL_RD   = 2'b10;
  localparam logic [1:0] SEL_PC   = 2'b11;

  // Destination selects that target the register file.
  function automatic logic is_rf_sel(input logic [1:0] sel);
    return (sel == SEL_RT) || (sel == SEL_RD);
  endfunction

  // An entry may leave the head this cycle.
  function automatic logic can_retire(input logic [1:0] sel, input logic rdy);
    return !is_rf_sel(sel) || rdy;
  endfunction

  // Queue storage (data path, never reset)
  logic [1:0]        sel_mem  [DEPTH];
  logic [REG_AW-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Control state
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Output registers
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              pc_we_q, pc_we_d;
  logic [DATA_W-1:0] pc_value_q, pc_value_d;

  // Combinational handshake / issue signals
  logic              push;
  logic              pop;
  logic              bypass;
  logic              enq;
  logic [REG_AW-1:0] in_addr;
  logic [1:0]        head_sel;
  logic              iss_valid;
  logic [1:0]        iss_sel;
  logic [REG_AW-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;

  always_comb begin
    in_addr  = (in_sel == SEL_RT) ? in_rt : in_rd;
    head_sel = sel_mem[rptr_q];

    // Full is judged on registered occupancy only; a same-cycle pop does
    // not open a slot.
    in_ready = (count_q < FULL);
    push     = in_valid && in_ready;
    pop      = (count_q != '0) && can_retire(head_sel, rf_ready);

    bypass = 1'b0;
`ifdef WB_BYPASS_EN
    bypass = push && (count_q == '0) && can_retire(in_sel, rf_ready);
`endif
    enq = push && !bypass;

    // The queue is empty whenever bypass is taken, so the two issue
    // sources never compete.
    iss_valid = pop || bypass;
    iss_sel   = bypass ? in_sel  : head_sel;
    iss_addr  = bypass ? in_addr : addr_mem[rptr_q];
    iss_data  = bypass ? in_data : data_mem[rptr_q];

    wptr_d = enq ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;

    count_d = count_q;
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Register 0 and "none" entries retire silently.
    rf_we_d    = iss_valid && is_rf_sel(iss_sel) && (iss_addr != '0);
    pc_we_d    = iss_valid && (iss_sel == SEL_PC);
    rf_waddr_d = rf_we_d ? iss_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? iss_data : rf_wdata_q;
    pc_value_d = pc_we_d ? iss_data : pc_value_q;
  end

  // ---- queue write stage ----
  always_ff @(posedge clk) begin
    if (enq) begin
      sel_mem[wptr_q]  <= in_sel;
      addr_mem[wptr_q] <= in_addr;
      data_mem[wptr_q] <= in_data;
    end
  end

  // ---- pointer / occupancy and output stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_we_q    <= 1'b0;
      pc_value_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pc_we_q    <= pc_we_d;
      pc_value_q <= pc_value_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pc_we    = pc_we_q;
  assign pc_value = pc_value_q;
  assign count    = count_q;

  // SEL_NONE is documented above; referenced here so its meaning stays
  // tied to the encoding even though no path tests for it directly.
  logic unused_sel_none;
  assign unused_sel_none = (in_sel == SEL_NONE);

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP     = 1'b1;
  localparam int EXP_LAT = 0;
`else
  localparam bit BYP     = 1'b0;
  localparam int EXP_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [REG_AW-1:0] in_rt, in_rd;
  logic [DATA_W-1:0] in_data;
  logic              rf_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_we;
  logic [DATA_W-1:0] pc_value;
  logic [$clog2(DEPTH):0] count;

  writeback_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_rt(in_rt), .in_rd(in_rd), .in_data(in_data),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc_we(pc_we), .pc_value(pc_value), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                is_pc;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t       sb[$];   // expected visible writes/redirects, in order
  logic [1:0] mq[$];   // model queue of pending destination selects
  logic [REG_AW-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic [DATA_W-1:0] last_pc;
  bit mon_en = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit needs_rf(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  // Apply current inputs for one clock edge, updating the reference model
  // from the same inputs, then return shortly after the following falling edge.
  task automatic tick();
    bit   acc, ret, byp;
    exp_t e;
    if (rst) begin
      mq.delete();
      sb.delete();
      last_addr = '0;
      last_data = '0;
      last_pc   = '0;
    end else begin
      ret = (mq.size() > 0) && (!needs_rf(mq[0]) || rf_ready);
      acc = in_valid && (mq.size() < DEPTH);
      byp = BYP && acc && (mq.size() == 0) && (!needs_rf(in_sel) || rf_ready);
      if (ret) void'(mq.pop_front());
      if (acc && !byp) mq.push_back(in_sel);
      if (acc) begin
        if (in_sel == 2'b11) begin
          e.is_pc = 1'b1; e.addr = '0; e.data = in_data;
          sb.push_back(e);
        end else if (in_sel != 2'b00) begin
          e.is_pc = 1'b0;
          e.addr  = (in_sel == 2'b01) ? in_rt : in_rd;
          e.data  = in_data;
          if (e.addr != '0) sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares every output event against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("we_exclusive", {63'd0, rf_we & pc_we}, 64'd0);
      if (rf_we) begin
        chk("rf_expected", {63'd0, (sb.size() > 0) && !sb[0].is_pc}, 64'd1);
        if ((sb.size() > 0) && !sb[0].is_pc) begin
          e = sb.pop_front();
          chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
          chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        chk("rf_waddr_hold", 64'(rf_waddr), 64'(last_addr));
        chk("rf_wdata_hold", 64'(rf_wdata), 64'(last_data));
      end
      if (pc_we) begin
        chk("pc_expected", {63'd0, (sb.size() > 0) && sb[0].is_pc}, 64'd1);
        if ((sb.size() > 0) && sb[0].is_pc) begin
          e = sb.pop_front();
          chk("pc_value", 64'(pc_value), 64'(e.data));
          last_pc = e.data;
        end
      end else begin
        chk("pc_value_hold", 64'(pc_value), 64'(last_pc));
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < DEPTH});
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_sel = 2'b00; in_rt = '0; in_rd = '0; in_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit any_we;
    rst = 1'b1; rf_ready = 1'b1;
    idle_inputs();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);

    // Single rt write, latency check
    in_valid = 1'b1; in_sel = 2'b01; in_rt = 5'd5; in_rd = 5'd9; in_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    n = 0;
    while (!rf_we && n < 4) begin tick(); n++; end
    chk("lat_rf", 64'(n), 64'(EXP_LAT));
    chk("d1_waddr", 64'(rf_waddr), 64'd5);
    chk("d1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("d1_count", 64'(count), 64'd0);
    tick();
    chk("d1_we_once", {63'd0, rf_we}, 64'd0);

    // Fill under stall, overflow push ignored, then drain in order
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_sel = 2'b10; in_rd = REG_AW'(i); in_rt = 5'd0;
      in_data = 32'h1100 + DATA_W'(i);
      tick();
      chk("stall_no_we", {63'd0, rf_we}, 64'd0);
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    in_rd = 5'd9; in_data = 32'h9999;
    tick();
    chk("overflow_count", 64'(count), 64'd4);
    idle_inputs();
    rf_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_we", {63'd0, rf_we}, 64'd1);
      chk("drain_addr", 64'(rf_waddr), 64'(i));
    end
    tick();
    chk("drain_end_we", {63'd0, rf_we}, 64'd0);
    chk("drain_end_count", 64'(count), 64'd0);

    // PC redirect retires without rf_ready
    rf_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b11; in_data = 32'h00400020;
    tick();
    idle_inputs();
    n = 0;
    while (!pc_we && n < 4) begin tick(); n++; end
    chk("lat_pc", 64'(n), 64'(EXP_LAT));
    chk("pc_val", 64'(pc_value), 64'h00400020);
    chk("pc_rf_we", {63'd0, rf_we}, 64'd0);
    tick();
    chk("pc_once", {63'd0, pc_we}, 64'd0);

    // Register 0 and "none" retire silently
    rf_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b01; in_rt = 5'd0; in_rd = 5'd3; in_data = 32'h1234;
    tick();
    in_sel = 2'b00; in_data = 32'h5678;
    tick();
    idle_inputs();
    any_we = rf_we | pc_we;
    for (int i = 0; i < 3; i++) begin tick(); any_we |= rf_we | pc_we; end
    chk("silent_we", {63'd0, any_we}, 64'd0);
    chk("silent_count", 64'(count), 64'd0);

    // Reset mid-operation discards entries; request during reset ignored
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 2'b10; in_rd = 5'd7; in_data = 32'hA0 + DATA_W'(i);
      tick();
    end
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1; in_rd = 5'd8;
    tick();
    rst = 1'b0; idle_inputs(); rf_ready = 1'b1;
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_waddr", 64'(rf_waddr), 64'd0);
    any_we = rf_we | pc_we;
    for (int i = 0; i < 4; i++) begin tick(); any_we |= rf_we | pc_we; end
    chk("post_rst_we", {63'd0, any_we}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 2'($urandom_range(0, 3));
      in_rt    = REG_AW'($urandom_range(0, 7));
      in_rd    = REG_AW'($urandom_range(0, 7));
      in_data  = $urandom;
      rf_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; idle_inputs(); rf_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || count != 0) && n < 20) begin tick(); n++; end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_count", 64'(count), 64'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result/PC data width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-number width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning writeback queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  writeback request present.
REQ-007 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-008 SHALL have port in_sel  input  2  destination: 00 none, 01 rt, 10 rd, 11 pc.
REQ-009 SHALL have ports in_rt and in_rd  input  REG_AW  candidate register numbers.
REQ-010 SHALL have port in_data  input  DATA_W  result value.
REQ-011 SHALL have port rf_ready  input  1  register file accepts a write this cycle.
REQ-012 SHALL have ports rf_we (1), rf_waddr (REG_AW), rf_wdata (DATA_W)  output  registered register-file write.
REQ-013 SHALL have ports pc_we (1), pc_value (DATA_W)  output  registered PC redirect.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 SHALL accept a request on an edge where in_valid and in_ready are both 1; it SHALL capture sel, selected register number (rt if 01, else rd) and data.
REQ-016 SHALL drive in_ready = (count < DEPTH), from registered state only; no push when full, even if a pop occurs the same cycle.
REQ-017 SHALL keep entries in strict FIFO order; read/write pointers wrap modulo DEPTH.
REQ-018 SHALL retire the head entry on an edge where the queue is non-empty and: head sel is 01/10 and rf_ready=1; or head sel is 11 or 00 (no rf_ready needed).
REQ-019 On retiring an 01/10 head, rf_we SHALL be 1 for exactly the following cycle with rf_waddr/rf_wdata from the entry; pc_we SHALL be 0.
REQ-020 On retiring an 11 head, pc_we SHALL be 1 for exactly the following cycle with pc_value = entry data; rf_we SHALL be 0.
REQ-021 A head with sel 00, or sel 01/10 with register number 0, SHALL retire with rf_we=0 and pc_we=0 (zero register never written).
REQ-022 SHALL retire at most one entry per cycle; rf_we and pc_we SHALL never both be 1.
REQ-023 A 01/10 head with rf_ready=0 SHALL remain at the head; rf_we SHALL be 0 that cycle.
REQ-024 Simultaneous accept and retire SHALL leave count unchanged; accept-only +1; retire-only -1.
REQ-025 Latency (macro undefined): request accepted at edge N into an empty queue, rf_ready=1 -> write visible on outputs after edge N+1.
REQ-026 rf_waddr, rf_wdata, pc_value SHALL hold their last value when the corresponding enable is 0.

Reset
REQ-027 While rst=1 at an edge: count=0, pointers=0, rf_we=0, pc_we=0, rf_waddr=0, rf_wdata=0, pc_value=0, in_ready=1 after the edge.
REQ-028 Reset mid-operation SHALL discard all queued entries; no write or redirect issues for them afterwards.
REQ-029 A request presented during the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro WB_BYPASS_EN: if defined, a request accepted while count=0 and output stage free (no stall) SHALL be issued directly to outputs on the same edge (latency edge N), not enqueued; count stays 0.
REQ-031 Without WB_BYPASS_EN, every request SHALL pass through the queue (REQ-025 latency).

Verification
REQ-032 Reset, push sel=01 rt=5 data=0xDEADBEEF, rf_ready=1 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle after retire edge; count back to 0.
REQ-033 Hold rf_ready=0, push 4 sel=10 entries rd=1..4 -> count=4, in_ready=0, 5th push ignored; release -> rd 1,2,3,4 written on consecutive cycles.
REQ-034 Push sel=11 data=0x00400020 with rf_ready=0 -> pc_we=1, pc_value=0x00400020 one cycle, rf_we=0.
REQ-035 Push sel=01 rt=0 data=0x1234 and sel=00 -> both retire, rf_we and pc_we stay 0.
REQ-036 Fill queue to 3, assert rst one cycle -> count=0, no rf_we/pc_we afterwards; with WB_BYPASS_EN, single push to empty queue -> rf_we=1 after edge N.
